// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receiver.
// State encoding, default oversampling rate and parity mode values.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRK_WAIT
    } rx_state_t;

    localparam int TICK_PER_BIT_DEF = 16;
    localparam int M_DEF            = TICK_PER_BIT_DEF / 2;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic int mid_tick(input int tpb);
        return tpb / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit tick counter and 3-sample majority vote.
// bit_done and tcnt_wrap are combinational strobes on the qualifying tick.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int TICK_PER_BIT = TICK_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic rx,
    input  logic run,
    output logic line,
    output logic bit_val,
    output logic bit_done,
    output logic tcnt_wrap
);

    localparam int M  = mid_tick(TICK_PER_BIT);
    localparam int TW = $clog2(TICK_PER_BIT);

    logic [1:0]    sync;
    logic [TW-1:0] tcnt;
    logic          s0;
    logic          s1;

    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], rx};
    end

    assign line = sync[1];

    // tcnt sits at 0 while idle so the first bit period starts cleanly
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
            s0   <= 1'b1;
            s1   <= 1'b1;
        end else if (!run) begin
            tcnt <= '0;
        end else if (tick) begin
            if (tcnt == TW'(M - 1)) s0 <= line;
            if (tcnt == TW'(M))     s1 <= line;
            if (tcnt == TW'(TICK_PER_BIT - 1)) tcnt <= '0;
            else                               tcnt <= tcnt + TW'(1);
        end
    end

    assign bit_val   = (s0 & s1) | (s0 & line) | (s1 & line);
    assign bit_done  = run && tick && (tcnt == TW'(M + 1));
    assign tcnt_wrap = run && tick && (tcnt == TW'(TICK_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: frame FSM, parity/stop/break checks and a
// one-entry holding register with a valid/ready handshake.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int TICK_PER_BIT = TICK_PER_BIT_DEF,
    parameter int DATA_BITS    = 8
) (
    input  logic       i_Clock,
    input  logic       i_reset,
    input  logic       i_sample_tick,
    input  logic       i_enable,
    input  logic       i_RX,
    input  logic       i_parity_en,
    input  logic       i_parity_odd,
    input  logic       i_two_stop,
    input  logic       i_RX_ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Data,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_break,
    output logic       o_overrun,
    output logic       o_RX_Active
);

    localparam int BW = $clog2(DATA_BITS);

    rx_state_t state;
    rx_state_t state_n;

    logic line;
    logic bit_val;
    logic bit_done;
    logic tcnt_wrap;

    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bcnt;
    logic                 pbit;
    logic                 perr;
    logic                 stop1_ok;
    logic                 par_target;
    logic                 brk_frame;

    logic complete;
    logic brk_hit;
    logic ferr_n;
    logic xfer;

    logic       dv;
    logic [7:0] data_q;
    logic       perr_q;
    logic       ferr_q;
    logic       brk_q;
    logic       ovr_q;

    uart_rx_sampler #(
        .TICK_PER_BIT(TICK_PER_BIT)
    ) u_sampler (
        .clk      (i_Clock),
        .reset    (i_reset),
        .tick     (i_sample_tick),
        .rx       (i_RX),
        .run      (state != IDLE),
        .line     (line),
        .bit_val  (bit_val),
        .bit_done (bit_done),
        .tcnt_wrap(tcnt_wrap)
    );

    assign par_target = i_parity_odd ? PARITY_ODD : PARITY_EVEN;
    assign brk_frame  = (shreg == '0) && (!i_parity_en || !pbit) && !bit_val;

    always_ff @(posedge i_Clock) begin
        if (i_reset)        state <= IDLE;
        else if (!i_enable) state <= IDLE;
        else                state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (i_sample_tick && !line) state_n = START;
            START:
                if (bit_done && bit_val) state_n = IDLE;
                else if (tcnt_wrap)      state_n = DATA;
            DATA:
                if (tcnt_wrap && bcnt == BW'(DATA_BITS - 1))
                    state_n = i_parity_en ? PARITY : STOP1;
            PARITY:
                if (tcnt_wrap) state_n = STOP1;
            STOP1:
                if (bit_done) begin
                    if (brk_frame)        state_n = BRK_WAIT;
                    else if (!i_two_stop) state_n = IDLE;
                end else if (tcnt_wrap && i_two_stop) begin
                    state_n = STOP2;
                end
            STOP2:
                if (bit_done) state_n = IDLE;
            BRK_WAIT:
                if (i_sample_tick && line) state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    always_comb begin
        complete = 1'b0;
        brk_hit  = 1'b0;
        ferr_n   = 1'b0;
        if (i_enable && bit_done) begin
            if (state == STOP1) begin
                if (brk_frame) begin
                    brk_hit = 1'b1;
                end else if (!i_two_stop) begin
                    complete = 1'b1;
                    ferr_n   = !bit_val;
                end
            end else if (state == STOP2) begin
                complete = 1'b1;
                ferr_n   = !stop1_ok || !bit_val;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_reset) begin
            shreg    <= '0;
            bcnt     <= '0;
            pbit     <= 1'b0;
            perr     <= 1'b0;
            stop1_ok <= 1'b1;
        end else begin
            case (state)
                START: begin
                    bcnt <= '0;
                    pbit <= 1'b0;
                    perr <= 1'b0;
                end
                DATA: begin
                    if (bit_done)  shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    if (tcnt_wrap) bcnt  <= bcnt + BW'(1);
                end
                PARITY:
                    if (bit_done) begin
                        pbit <= bit_val;
                        perr <= ((^shreg) ^ bit_val) != par_target;
                    end
                STOP1:
                    if (bit_done) stop1_ok <= bit_val;
                default: ;
            endcase
        end
    end

    assign xfer = dv && i_RX_ready;

    // a completion only loads when the slot is free or being emptied
    always_ff @(posedge i_Clock) begin
        if (i_reset) begin
            dv     <= 1'b0;
            data_q <= 8'h00;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            brk_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            brk_q <= brk_hit;
            ovr_q <= complete && dv && !xfer;
            if (complete && (!dv || xfer)) begin
                dv     <= 1'b1;
                data_q <= 8'(shreg);
                perr_q <= perr;
                ferr_q <= ferr_n;
            end else if (xfer) begin
                dv <= 1'b0;
            end
        end
    end

    assign o_RX_DV      = dv;
    assign o_RX_Data    = data_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_break      = brk_q;
    assign o_overrun    = ovr_q;
    assign o_RX_Active  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Randomized bench for uart_rx_framed with a frame-level reference model.
module tb_uart_rx_framed;

    localparam int TPB = 16;
    localparam int DB  = 8;
    localparam int M   = TPB / 2;

    logic clk = 1'b0;
    logic tick = 1'b0;
    logic [1:0] div = 2'd0;
    logic reset, enable, rx, pen, podd, two, ready;
    logic dv, perr, ferr, brk, ovr, active;
    logic [7:0] data;

    uart_rx_framed #(
        .TICK_PER_BIT(TPB),
        .DATA_BITS   (DB)
    ) dut (
        .i_Clock      (clk),
        .i_reset      (reset),
        .i_sample_tick(tick),
        .i_enable     (enable),
        .i_RX         (rx),
        .i_parity_en  (pen),
        .i_parity_odd (podd),
        .i_two_stop   (two),
        .i_RX_ready   (ready),
        .o_RX_DV      (dv),
        .o_RX_Data    (data),
        .o_parity_err (perr),
        .o_frame_err  (ferr),
        .o_break      (brk),
        .o_overrun    (ovr),
        .o_RX_Active  (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div  <= div + 2'd1;
        tick <= (div == 2'd3);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int exp_brk = 0, exp_ovr = 0;
    int brk_rise = 0, brk_cyc = 0, ovr_rise = 0, ovr_cyc = 0, dv_cyc = 0;
    logic brk_d = 1'b0, ovr_d = 1'b0;

    always @(negedge clk) begin
        if (dv && ready) got_q.push_back({perr, ferr, data});
        if (dv) dv_cyc++;
        if (brk) brk_cyc++;
        if (brk && !brk_d) brk_rise++;
        if (ovr) ovr_cyc++;
        if (ovr && !ovr_d) ovr_rise++;
        brk_d = brk;
        ovr_d = ovr;
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!tick);
        end
        #1;
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        wait_ticks(n);
    endtask

    task automatic send_flip(input logic b);
        rx = b;
        wait_ticks(M);
        rx = ~b;
        wait_ticks(1);
        rx = b;
        wait_ticks(TPB - M - 1);
    endtask

    // completion lands M+1 sampled ticks into the stop bit, i.e. the
    // (M+3)rd tick after the bit is driven once sync and start alignment apply
    task automatic send_stop(input logic b, input bit rdy_at_done);
        if (!rdy_at_done) begin
            send_bit(b, TPB);
        end else begin
            rx = b;
            wait_ticks(M + 2);
            do @(negedge clk); while (!tick);
            ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
            wait_ticks(TPB - M - 3);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit p_en,
                              input bit p_odd, input bit p_flip,
                              input bit two_s, input bit s1, input bit s2,
                              input int flip_idx, input int gap_bits,
                              input bit rdy_at_done);
        logic pb;
        pb = (^d) ^ p_odd ^ p_flip;
        pen = p_en;
        podd = p_odd;
        two = two_s;
        if (d == 8'h00 && (!p_en || !pb) && !s1)
            exp_brk++;
        else
            exp_q.push_back({p_en && (((^d) ^ pb) != p_odd),
                             !s1 || (two_s && !s2), d});
        send_bit(1'b0, TPB);
        for (int i = 0; i < DB; i++) begin
            if (i == flip_idx) send_flip(d[i]);
            else               send_bit(d[i], TPB);
        end
        if (p_en) send_bit(pb, TPB);
        if (two_s) begin
            send_bit(s1, TPB);
            send_stop(s2, rdy_at_done);
        end else begin
            send_stop(s1, rdy_at_done);
        end
        if (gap_bits > 0) send_bit(1'b1, gap_bits * TPB);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, "_brk"}, brk_rise, exp_brk);
        chk({tag, "_ovr"}, ovr_rise, exp_ovr);
    endtask

    initial begin
        logic [7:0] d;
        int fi;
        reset = 1'b1;
        enable = 1'b1;
        rx = 1'b1;
        pen = 1'b0;
        podd = 1'b0;
        two = 1'b0;
        ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_dv", dv, 0);
        chk("rst_data", data, 8'h00);
        chk("rst_flags", {perr, ferr, brk, ovr}, 0);
        chk("rst_active", active, 0);
        reset = 1'b0;
        wait_ticks(4);

        dv_cyc = 0;
        send_frame(8'h3F, 0, 0, 0, 0, 1, 1, -1, 2, 0);
        chk("dv_width", dv_cyc, 1);
        compare("8n1");

        send_frame(8'hA5, 1, 0, 1, 0, 1, 1, -1, 2, 0);
        send_frame(8'h01, 1, 1, 0, 1, 1, 0, -1, 2, 0);
        compare("parity_stop");

        rx = 1'b0;
        wait_ticks(2);
        chk("glitch_start", active, 1);
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(M + 8);
        chk("glitch_idle", active, 0);
        send_frame(8'hB6, 0, 0, 0, 0, 1, 1, 2, 2, 0);
        send_frame(8'h49, 1, 1, 0, 0, 1, 1, 5, 2, 0);
        compare("glitch_flip");

        send_bit(1'b0, 20 * TPB);
        send_bit(1'b1, 2 * TPB);
        exp_brk++;
        send_frame(8'h55, 0, 0, 0, 0, 1, 1, -1, 2, 0);
        compare("break");

        for (int n = 0; n < 24; n++) begin
            bit p_en, p_odd, p_flip, two_s, s1, s2;
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            p_en = 1'($urandom);
            p_odd = 1'($urandom);
            p_flip = p_en && ($urandom_range(0, 3) == 0);
            two_s = 1'($urandom);
            s1 = ($urandom_range(0, 5) != 0);
            s2 = ($urandom_range(0, 5) != 0);
            fi = $urandom_range(0, 11);
            if (fi >= DB) fi = -1;
            send_frame(d, p_en, p_odd, p_flip, two_s, s1, s2, fi, 2, 0);
        end
        compare("random");

        ready = 1'b0;
        send_frame(8'h11, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        send_frame(8'h22, 0, 0, 0, 0, 1, 1, -1, 2, 0);
        void'(exp_q.pop_back());
        exp_ovr++;
        chk("ovr_held_dv", dv, 1);
        chk("ovr_held_data", data, 8'h11);
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        wait_ticks(2);
        send_frame(8'h11, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        send_frame(8'h22, 0, 0, 0, 0, 1, 1, -1, 1, 1);
        chk("same_cycle_data", data, 8'h22);
        ready = 1'b1;
        wait_ticks(2);
        compare("overrun");

        ready = 1'b0;
        send_frame(8'h5A, 0, 0, 0, 0, 1, 1, -1, 1, 0);
        exp_q.delete();
        send_bit(1'b0, TPB);
        send_bit(1'b1, 3 * TPB);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_dv", dv, 0);
        chk("midrst_data", data, 8'h00);
        chk("midrst_flags", {perr, ferr, brk, ovr}, 0);
        chk("midrst_active", active, 0);
        reset = 1'b0;
        ready = 1'b1;
        wait_ticks(2 * TPB);

        send_bit(1'b0, TPB);
        send_bit(1'b1, 4 * TPB);
        enable = 1'b0;
        wait_ticks(1);
        chk("dis_active", active, 0);
        send_bit(1'b1, 2 * TPB);
        enable = 1'b1;
        wait_ticks(TPB);
        send_frame(8'hC3, 0, 0, 0, 0, 1, 1, -1, 2, 0);
        compare("rst_enable");

        chk("brk_width", brk_cyc, exp_brk);
        chk("ovr_width", ovr_cyc, exp_ovr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
